run_lock_detector: RTL and testbench

RUN_LOCK_DETECTOR -- requirements
Module: run_lock_detector

---
 rtl/run_lock_detector.sv | 160 ++++++++++++++++
 tb/tb_run_lock_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_lock_detector.sv
// Run-length lock detector: locks after RUN_LEN identical bits and tolerates HOLD_TOL opposite bits while locked.
// Optional feature macro RUN_LOCK_LOSS_CNT_EN adds clr_loss / loss_cnt, a saturating count of lock losses.
module run_lock_detector #(
  parameter  int RUN_LEN  = 5,
  parameter  int HOLD_TOL = 0,
  localparam int CNT_W    = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  output logic             lock,
  output logic             lock_val,
  output logic [CNT_W-1:0] run_cnt,
  output logic             lock_rise,
  output logic             lock_fall,
  output logic [1:0]       state
`ifdef RUN_LOCK_LOSS_CNT_EN
  ,
  input  logic             clr_loss,
  output logic [7:0]       loss_cnt
`endif
);

  if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
    $error("run_lock_detector: RUN_LEN=%0d outside 2..255", RUN_LEN);
  end
  if (HOLD_TOL < 0 || HOLD_TOL > RUN_LEN - 2) begin : g_bad_hold_tol
    $error("run_lock_detector: HOLD_TOL=%0d outside 0..RUN_LEN-2", HOLD_TOL);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] DROP_CNT = CNT_W'(HOLD_TOL + 1);
  localparam logic [7:0]       TOL      = 8'(HOLD_TOL);

  state_e           state_q, state_d;
  logic             run_val_q, run_val_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic [7:0]       miss_inc;
  logic             lock_q, lock_d;
  logic             lock_val_q, lock_val_d;
  logic             lock_rise_q, lock_rise_d;
  logic             lock_fall_q, lock_fall_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    run_val_d   = run_val_q;
    run_cnt_d   = run_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lock_d      = lock_q;
    lock_val_d  = lock_val_q;
    lock_rise_d = 1'b0;
    lock_fall_d = 1'b0;
    miss_inc    = miss_cnt_q + 8'd1;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d   = HUNT;
          run_val_d = din;
          run_cnt_d = CNT_W'(1);
        end
        HUNT: begin
          if (din == run_val_q) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
            if (run_cnt_q == RUN_MAX - CNT_W'(1)) begin
              state_d     = LOCKED;
              lock_d      = 1'b1;
              lock_val_d  = run_val_q;
              lock_rise_d = 1'b1;
            end
          end else begin
            run_val_d = din;
            run_cnt_d = CNT_W'(1);
          end
        end
        LOCKED, HOLD: begin
          // LOCKED always has miss_cnt_q=0, so its first miss and HOLD's later misses share one path.
          if (din == lock_val_q) begin
            state_d    = LOCKED;
            miss_cnt_d = '0;
          end else if (miss_inc > TOL) begin
            state_d     = HUNT;
            lock_d      = 1'b0;
            lock_val_d  = 1'b0;
            lock_fall_d = 1'b1;
            run_val_d   = ~lock_val_q;
            run_cnt_d   = DROP_CNT;
            miss_cnt_d  = '0;
          end else begin
            state_d    = HOLD;
            miss_cnt_d = miss_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef RUN_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clr_loss) begin
      loss_cnt_d = '0;
    end else if (lock_fall_d && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  assign loss_cnt = loss_cnt_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    if (!rst_n) begin
      state_q     <= IDLE;
      run_val_q   <= 1'b0;
      run_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
      lock_val_q  <= 1'b0;
      lock_rise_q <= 1'b0;
      lock_fall_q <= 1'b0;
`ifdef RUN_LOCK_LOSS_CNT_EN
      loss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_val_q   <= run_val_d;
      run_cnt_q   <= run_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
      lock_val_q  <= lock_val_d;
      lock_rise_q <= lock_rise_d;
      lock_fall_q <= lock_fall_d;
`ifdef RUN_LOCK_LOSS_CNT_EN
      loss_cnt_q  <= loss_cnt_d;
`endif
    end
  end

  assign lock      = lock_q;
  assign lock_val  = lock_val_q;
  assign run_cnt   = run_cnt_q;
  assign lock_rise = lock_rise_q;
  assign lock_fall = lock_fall_q;
  assign state     = state_q;

endmodule

// File: tb/tb_run_lock_detector.sv
// Scoreboard bench for run_lock_detector: two instances (HOLD_TOL=0 and 1) share one stimulus stream,
// a run-based reference model queues expected outputs and a monitor compares them each cycle.
module tb_run_lock_detector;

  localparam int RUN = 5;

  typedef struct packed {
    logic       lock;
    logic       lock_val;
    logic [2:0] run_cnt;
    logic       rise;
    logic       fall;
    logic [1:0] state;
    logic [7:0] loss;
  } obs_t;

  // Model state: a run of 'run' copies of 'val'; once locked, 'miss' counts consecutive opposite bits.
  typedef struct {
    bit started;
    bit locked;
    bit val;
    int run;
    int miss;
    bit rise;
    bit fall;
    int loss;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       en = 1'b0;
  logic       clr_loss = 1'b0;

  logic       lock0, lock_val0, rise0, fall0;
  logic       lock1, lock_val1, rise1, fall1;
  logic [2:0] run_cnt0, run_cnt1;
  logic [1:0] state0, state1;
  logic [7:0] loss0, loss1;
  obs_t       act0, act1;

  obs_t       q0[$];
  obs_t       q1[$];
  mdl_t       m0, m1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  run_lock_detector #(.RUN_LEN(RUN), .HOLD_TOL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en),
    .lock(lock0), .lock_val(lock_val0), .run_cnt(run_cnt0),
    .lock_rise(rise0), .lock_fall(fall0), .state(state0)
`ifdef RUN_LOCK_LOSS_CNT_EN
    , .clr_loss(clr_loss), .loss_cnt(loss0)
`endif
  );

  run_lock_detector #(.RUN_LEN(RUN), .HOLD_TOL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en),
    .lock(lock1), .lock_val(lock_val1), .run_cnt(run_cnt1),
    .lock_rise(rise1), .lock_fall(fall1), .state(state1)
`ifdef RUN_LOCK_LOSS_CNT_EN
    , .clr_loss(clr_loss), .loss_cnt(loss1)
`endif
  );

`ifndef RUN_LOCK_LOSS_CNT_EN
  assign loss0 = 8'd0;
  assign loss1 = 8'd0;
`endif

  assign act0 = {lock0, lock_val0, run_cnt0, rise0, fall0, state0, loss0};
  assign act1 = {lock1, lock_val1, run_cnt1, rise1, fall1, state1, loss1};

  function automatic mdl_t mdl_step(mdl_t m, bit rst, bit e, bit b, bit clr, int tol);
    mdl_t n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!rst) begin
      n = '{default: 0};
      return n;
    end
    if (e) begin
      if (!m.started) begin
        n.started = 1'b1;
        n.val     = b;
        n.run     = 1;
      end else if (!m.locked) begin
        if (b == m.val) n.run = m.run + 1;
        else begin
          n.val = b;
          n.run = 1;
        end
        if (n.run == RUN) begin
          n.locked = 1'b1;
          n.rise   = 1'b1;
        end
      end else if (b == m.val) begin
        n.miss = 0;
      end else begin
        n.miss = m.miss + 1;
        if (n.miss > tol) begin
          n.locked = 1'b0;
          n.fall   = 1'b1;
          n.val    = b;
          n.run    = n.miss;
          n.miss   = 0;
        end
      end
    end
    if (clr) n.loss = 0;
    else if (n.fall && n.loss < 255) n.loss = n.loss + 1;
    return n;
  endfunction

  function automatic obs_t mdl_obs(mdl_t m);
    obs_t o;
    o.lock     = m.locked;
    o.lock_val = m.locked & m.val;
    o.run_cnt  = 3'(m.run);
    o.rise     = m.rise;
    o.fall     = m.fall;
    if (!m.started)     o.state = 2'd0;
    else if (!m.locked) o.state = 2'd1;
    else if (m.miss == 0) o.state = 2'd2;
    else                o.state = 2'd3;
`ifdef RUN_LOCK_LOSS_CNT_EN
    o.loss = 8'(m.loss);
`else
    o.loss = 8'd0;
`endif
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got lock=%b val=%b cnt=%0d rise=%b fall=%b st=%0d loss=%0d exp lock=%b val=%b cnt=%0d rise=%b fall=%b st=%0d loss=%0d",
               name, cyc, got.lock, got.lock_val, got.run_cnt, got.rise, got.fall, got.state, got.loss,
               exp.lock, exp.lock_val, exp.run_cnt, exp.rise, exp.fall, exp.state, exp.loss);
    end
  endtask

  task automatic step(input bit b, input bit e, input bit r, input bit c);
    @(negedge clk);
    din      = b;
    en       = e;
    rst_n    = r;
    clr_loss = c;
    @(posedge clk);
    m0 = mdl_step(m0, r, e, b, c, 0);
    m1 = mdl_step(m1, r, e, b, c, 1);
    q0.push_back(mdl_obs(m0));
    q1.push_back(mdl_obs(m1));
  endtask

  task automatic bits(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("tol0", act0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("tol1", act1, e);
      end
    end
  end

  initial begin : driver
    bit b;
    m0 = '{default: 0};
    m1 = '{default: 0};

    // Reset, including with en=1 and din=1.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Lock on 1, drop on a 0, relock on 0.
    bits(1'b1, 5);
    bits(1'b0, 1);
    bits(1'b0, 4);

    // Locked on 1, a single 0 then 1; then two 0s and three more 0s.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bits(1'b1, 5);
    bits(1'b0, 1);
    bits(1'b1, 1);
    bits(1'b0, 2);
    bits(1'b0, 3);

    // Enable gap mid-run with din toggling.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bits(1'b1, 3);
    for (int i = 0; i < 10; i++) step(i[0], 1'b0, 1'b1, 1'b0);
    bits(1'b1, 2);

    // Reset while locked must not pulse lock_fall.
    bits(1'b1, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Three lock losses, then clr_loss on the bit that causes the fourth.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bits(1'b1, 5);
    bits(1'b0, 5);
    bits(1'b1, 5);
    bits(1'b0, 5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    bits(1'b1, 4);

    // Randomized runs with occasional enable gaps, resets and clears.
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) b = ~b;
      step(b, $urandom_range(9) != 0, $urandom_range(99) != 0, $urandom_range(49) == 0);
    end

    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) begin
      @(negedge clk);
      #2;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", q0.size(), q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
